// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Purpose  : Shared constants, the word type and a range-check helper for
//            register_file and its read ports.
// Revision : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int RF_WIDTH     = 32;
  localparam int RF_DEPTH     = 32;
  localparam int RF_ZERO_ADDR = 0;

  typedef logic signed [RF_WIDTH-1:0] rf_word_t;

  // True when an address selects a physically present entry (no wrap-around)
  function automatic logic rf_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module   : rf_read_port
// Purpose  : One combinational read port of register_file: address range
//            check, zero-register mask and optional write-first forwarding.
//            Build option: RF_BYPASS_EN enables Din -> data forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module rf_read_port import rf_pkg::*; #(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [AW-1:0]           addr,
  input  logic signed [WIDTH-1:0] mem [DEPTH],
`ifdef RF_BYPASS_EN
  input  logic                    rst,
  input  logic                    we,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [WIDTH-1:0] wr_data,
`endif
  output logic signed [WIDTH-1:0] data
);

  logic in_range;
  logic is_zero;

  assign in_range = rf_in_range(32'(addr), DEPTH);
  assign is_zero  = (ZERO_REG != 0) && (addr == AW'(RF_ZERO_ADDR));

  // Select stored word; out-of-range and zero-register reads return 0
  always_comb begin
    data = '0;
    if (in_range && !is_zero) begin
`ifdef RF_BYPASS_EN
      // A matching in-range, non-zero write forwards its data this cycle
      if (we && !rst && (wr_addr == addr))
        data = wr_data;
      else
        data = mem[addr];
`else
      data = mem[addr];
`endif
    end
  end

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Purpose  : DEPTH x WIDTH register file, one synchronous write port and two
//            combinational read ports, asynchronous active-high clear.
//            Build option: RF_BYPASS_EN selects write-first read behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module register_file import rf_pkg::*; #(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WE,
  input  logic [AW-1:0]           Awr,
  input  logic signed [WIDTH-1:0] Din,
  input  logic [AW-1:0]           Ard1,
  input  logic [AW-1:0]           Ard2,
  output logic signed [WIDTH-1:0] Dout1,
  output logic signed [WIDTH-1:0] Dout2
);

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic                    wr_ok;

  // Writes land only on present entries and never on the zero register
  assign wr_ok = WE && rf_in_range(32'(Awr), DEPTH) &&
                 !((ZERO_REG != 0) && (Awr == AW'(RF_ZERO_ADDR)));

  // Storage: async clear dominates any write in the same cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_ok) begin
      mem[Awr] <= Din;
    end
  end

  rf_read_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_rd1 (
    .addr    (Ard1),
    .mem     (mem),
`ifdef RF_BYPASS_EN
    .rst     (RST),
    .we      (WE),
    .wr_addr (Awr),
    .wr_data (Din),
`endif
    .data    (Dout1)
  );

  rf_read_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_rd2 (
    .addr    (Ard2),
    .mem     (mem),
`ifdef RF_BYPASS_EN
    .rst     (RST),
    .we      (WE),
    .wr_addr (Awr),
    .wr_data (Din),
`endif
    .data    (Dout2)
  );

endmodule
`default_nettype wire
